// File: rtl/uart_io_master_if.sv
// uart_io_master_if: groups the TX byte stream, RX byte stream and miniuart2 register port.
// Ports: tx_data/tx_valid/tx_ready (byte in), rx_data/rx_valid/rx_ready (byte out),
//        io_rd/io_wr/io_addr/io_din/io_dout (UART register bus).
interface uart_io_master_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              io_rd;
  logic              io_wr;
  logic              io_addr;
  logic [DATA_W-1:0] io_din;
  logic [DATA_W-1:0] io_dout;

  // master: the bus initiator (uart_io_master)
  modport master (
    input  tx_data, tx_valid, rx_ready, io_dout,
    output tx_ready, rx_data, rx_valid, io_rd, io_wr, io_addr, io_din
  );

  // slave: the stream producer/consumer plus the UART register side
  modport slave (
    output tx_data, tx_valid, rx_ready, io_dout,
    input  tx_ready, rx_data, rx_valid, io_rd, io_wr, io_addr, io_din
  );
endinterface

// File: rtl/uart_io_master.sv
// uart_io_master: polls a miniuart2 status register, writes queued TX bytes, streams received bytes out.
// Latency: a byte accepted while idle (UART idle, buffer empty) produces io_wr three cycles later.
// Backpressure: tx_ready drops when the TX buffer is full; RX bytes stay in the UART while rx_valid is held.
// Ports: clk_i, rst_ni (async, active-low), bus (uart_io_master_if.master), busy_o (FSM not in IDLE).
// Build option: UART_IO_TXFIFO_EN selects a TXFIFO_DEPTH-entry TX FIFO instead of a single holding register.

`ifdef UART_IO_TXFIFO_EN
// uart_io_txfifo: circular FIFO with one extra pointer bit so full/empty are exact across wrap.
// Latency: a written entry is readable the next cycle.
// Backpressure: full_o high blocks writes; a write while full is dropped.
module uart_io_txfifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              wr_vld_i,
  input  logic [DATA_W-1:0] wr_dat_i,
  output logic              full_o,
  input  logic              rd_en_i,
  output logic              rd_vld_o,
  output logic [DATA_W-1:0] rd_dat_o
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]       wr_ptr_q;
  logic [AW:0]       rd_ptr_q;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              wr_en;
  logic              rd_en;

  // Same index with differing wrap bits means the writer is a full lap ahead.
  assign full_o   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_vld_o = (wr_ptr_q != rd_ptr_q);
  assign rd_dat_o = mem_q[rd_ptr_q[AW-1:0]];
  assign wr_en    = wr_vld_i && !full_o;
  assign rd_en    = rd_en_i && rd_vld_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= wr_dat_i;
  end
endmodule
`endif

module uart_io_master #(
  parameter int DATA_W       = 8,
  parameter int POLL_GAP     = 16,
  parameter int TXFIFO_DEPTH = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  uart_io_master_if.master    bus,
  output logic                busy_o
);
  localparam int                GAP_W    = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [GAP_W-1:0]  GAP_LOAD = GAP_W'(POLL_GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_STAT_RD,
    S_STAT_EVAL,
    S_RX_RD,
    S_RX_CAP,
    S_TX_WR,
    S_GAP
  } state_t;

  state_t            state_q, state_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [DATA_W-1:0] io_din_q, io_din_d;
  logic              rx_valid_q;
  logic [DATA_W-1:0] rx_data_q;

  logic              tx_push;
  logic              tx_pop;
  logic              tx_full;
  logic              tx_nempty;
  logic [DATA_W-1:0] tx_head;

  assign tx_push      = bus.tx_valid && bus.tx_ready;
  assign tx_pop       = (state_q == S_TX_WR);
  assign bus.tx_ready = !tx_full;

`ifdef UART_IO_TXFIFO_EN
  uart_io_txfifo #(
    .DATA_W (DATA_W),
    .DEPTH  (TXFIFO_DEPTH)
  ) u_txfifo (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .wr_vld_i (tx_push),
    .wr_dat_i (bus.tx_data),
    .full_o   (tx_full),
    .rd_en_i  (tx_pop),
    .rd_vld_o (tx_nempty),
    .rd_dat_o (tx_head)
  );
`else
  logic              held_q;
  logic [DATA_W-1:0] held_dat_q;

  // Single holding register: tx_ready=0 while held, so push and pop never coincide.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      held_q     <= 1'b0;
      held_dat_q <= '0;
    end else if (tx_push) begin
      held_q     <= 1'b1;
      held_dat_q <= bus.tx_data;
    end else if (tx_pop) begin
      held_q     <= 1'b0;
    end
  end

  assign tx_full   = held_q;
  assign tx_nempty = held_q;
  assign tx_head   = held_dat_q;
`endif

  always_comb begin
    state_d  = state_q;
    gap_d    = gap_q;
    io_din_d = io_din_q;
    case (state_q)
      S_IDLE: begin
        if (gap_q != '0) gap_d = gap_q - GAP_W'(1);
        // The decrement that reaches zero also launches the poll, so GAP plus
        // POLL_GAP-1 IDLE cycles form the quiet window between polls. A byte being
        // pushed right now counts as pending so the write is not delayed a cycle.
        if ((gap_q <= GAP_W'(1)) || ((tx_nempty || tx_push) && !rx_valid_q))
          state_d = S_STAT_RD;
      end
      S_STAT_RD: state_d = S_STAT_EVAL;
      S_STAT_EVAL: begin
        // io_dout carries the status byte this cycle; RX wins over TX.
        if (bus.io_dout[0] && !rx_valid_q) begin
          state_d = S_RX_RD;
        end else if (!bus.io_dout[1] && tx_nempty) begin
          state_d  = S_TX_WR;
          io_din_d = tx_head;
        end else begin
          state_d = S_GAP;
        end
      end
      S_RX_RD:  state_d = S_RX_CAP;
      S_RX_CAP: state_d = S_GAP;
      S_TX_WR:  state_d = S_GAP;
      S_GAP: begin
        gap_d   = GAP_LOAD;
        state_d = S_IDLE;
      end
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      gap_q    <= '0;
      io_din_q <= '0;
    end else begin
      state_q  <= state_d;
      gap_q    <= gap_d;
      io_din_q <= io_din_d;
    end
  end

  // The data byte arrives on io_dout in the cycle after the RX_RD strobe.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
    end else if (state_q == S_RX_CAP) begin
      rx_valid_q <= 1'b1;
      rx_data_q  <= bus.io_dout;
    end else if (rx_valid_q && bus.rx_ready) begin
      rx_valid_q <= 1'b0;
    end
  end

  // Strobes decode straight from the state register so reset drops them at once.
  assign bus.io_rd    = (state_q == S_STAT_RD) || (state_q == S_RX_RD);
  assign bus.io_wr    = (state_q == S_TX_WR);
  assign bus.io_addr  = (state_q == S_STAT_RD);
  assign bus.io_din   = io_din_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.rx_data  = rx_data_q;
  assign busy_o       = (state_q != S_IDLE);
endmodule
